// File: rtl/fifo_read_logic_pkg.sv
// -----------------------------------------------------------------------------
// fifo_read_logic_pkg
// Shared definitions for the FIFO read and write pointer logic:
//   - rd_state_e  : read-side empty/ready state encoding
//   - PTR_MAX_W   : widest pointer the conversion helpers support
//   - gray2bin()  : Gray code to binary
//   - bin2gray()  : binary to Gray code
// The helpers work on PTR_MAX_W-bit values. Narrower pointers are zero-extended
// on the way in and truncated on the way out. Leading zeros do not change the
// result in either direction.
// -----------------------------------------------------------------------------
package fifo_read_logic_pkg;

  localparam int PTR_MAX_W = 16;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_READY = 1'b1
  } rd_state_e;

  // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_read_logic.sv
// -----------------------------------------------------------------------------
// fifo_read_logic
// Read-side pointer and empty-flag logic for a FIFO with DEPTH locations.
// The read address wraps from DEPTH-1 to 0. A read strobe is issued whenever a
// read is requested and the FIFO is not empty.
//
// Parameters
//   DEPTH      number of storage locations (DEPTH <= 2**PTR_SZ)
//   PTR_SZ     pointer width in bits (<= PTR_MAX_W)
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous reset, active low
//   rinc       read request
//   rq2_waddr  Gray-coded write address, already synchronized to clk
//   rempty     empty flag (registered)
//   read_en    memory read strobe for the current cycle (combinational)
//   raddr      binary read address (registered)
//   raddr_gray Gray-coded read address for the write-side synchronizer
//
// States
//   state   | meaning
//   S_EMPTY | no unread data; rempty = 1 and reads are blocked
//   S_READY | at least one unread word; rinc produces a read
// -----------------------------------------------------------------------------
module fifo_read_logic
  import fifo_read_logic_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int PTR_SZ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic [PTR_SZ-1:0] rq2_waddr,
  output logic              rempty,
  output logic              read_en,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ-1:0] raddr_gray
);

  localparam logic [PTR_SZ-1:0] LAST_ADDR = PTR_SZ'(DEPTH - 1);

  rd_state_e         r_state;
  rd_state_e         w_next_state;
  logic [PTR_SZ-1:0] r_raddr;
  logic [PTR_SZ-1:0] r_raddr_gray;
  logic [PTR_SZ-1:0] w_waddr;
  logic [PTR_SZ-1:0] w_raddr_tmp;
  logic              w_rempty_tmp;
  logic              w_read_en;

  // Decoded write address. Truncation back to PTR_SZ is exact because the
  // zero-extended upper Gray bits decode to zeros.
  assign w_waddr = PTR_SZ'(gray2bin(PTR_MAX_W'(rq2_waddr)));

  assign w_read_en = rinc & (r_state == S_READY);

  always_comb begin
    w_raddr_tmp = r_raddr;
    if (w_read_en) begin
      w_raddr_tmp = (r_raddr == LAST_ADDR) ? '0 : r_raddr + PTR_SZ'(1);
    end
  end

  // Empty is judged on the address after this cycle's read, against the
  // write address seen this cycle.
  assign w_rempty_tmp = (w_raddr_tmp == w_waddr);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (!w_rempty_tmp) w_next_state = S_READY;
      S_READY: if (w_rempty_tmp)  w_next_state = S_EMPTY;
      default: w_next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_EMPTY;
      r_raddr      <= '0;
      r_raddr_gray <= '0;
    end else begin
      r_state      <= w_next_state;
      r_raddr      <= w_raddr_tmp;
      r_raddr_gray <= PTR_SZ'(bin2gray(PTR_MAX_W'(w_raddr_tmp)));
    end
  end

  assign rempty     = (r_state == S_EMPTY);
  assign read_en    = w_read_en;
  assign raddr      = r_raddr;
  assign raddr_gray = r_raddr_gray;

endmodule

// File: tb/tb_fifo_read_logic.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_logic
// Self-checking bench for fifo_read_logic (DEPTH=3, PTR_SZ=2).
// First a directed table of {inputs, expected outputs} records is applied:
// reset, drain, reads while empty, wrap-around, held rinc, and reset during
// traffic. Then a randomized run is checked against a pointer/occupancy model.
// In each step, read_en is checked before the rising edge and the registered
// outputs are checked 1 ns after it.
// -----------------------------------------------------------------------------
module tb_fifo_read_logic;

  localparam int DEPTH  = 3;
  localparam int PTR_SZ = 2;

  logic              clk;
  logic              rst;
  logic              rinc;
  logic [PTR_SZ-1:0] rq2_waddr;
  logic              rempty;
  logic              read_en;
  logic [PTR_SZ-1:0] raddr;
  logic [PTR_SZ-1:0] raddr_gray;

  int n_pass  = 0;
  int n_total = 0;

  fifo_read_logic #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .rinc       (rinc),
    .rq2_waddr  (rq2_waddr),
    .rempty     (rempty),
    .read_en    (read_en),
    .raddr      (raddr),
    .raddr_gray (raddr_gray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rinc;
    logic [1:0] w;    // rq2_waddr (Gray)
    logic       re;   // read_en during the cycle
    logic [1:0] ra;   // raddr after the edge
    logic [1:0] rg;   // raddr_gray after the edge
    logic       em;   // rempty after the edge
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
  endtask

  task automatic step(input logic r, input logic ri, input logic [1:0] w,
                      input logic e_re, input logic [1:0] e_ra,
                      input logic [1:0] e_rg, input logic e_em, input int idx);
    rst       = r;
    rinc      = ri;
    rq2_waddr = w;
    @(negedge clk);
    check("read_en", idx, 32'(read_en), 32'(e_re));
    @(posedge clk);
    #1;
    check("raddr", idx, 32'(raddr), 32'(e_ra));
    check("raddr_gray", idx, 32'(raddr_gray), 32'(e_rg));
    check("rempty", idx, 32'(rempty), 32'(e_em));
  endtask

  // Bit i of the binary value is the parity of Gray bits i and above.
  function automatic int model_g2b(input int g);
    int b = 0;
    for (int i = 0; i < PTR_SZ; i++) b |= ($countones(g >> i) & 1) << i;
    return b;
  endfunction

  int  m_raddr;
  bit  m_empty;

  initial begin
    //           rst  rinc w     re   ra     rg     em
    tbl[0]  = '{1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 1'b1}; // reset, rinc ignored
    tbl[1]  = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0}; // waddr=2 -> not empty
    tbl[2]  = '{1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 2'd1, 1'b0}; // read 0
    tbl[3]  = '{1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 2'd3, 1'b1}; // read 1 -> empty
    tbl[4]  = '{1'b1, 1'b1, 2'd3, 1'b0, 2'd2, 2'd3, 1'b1}; // rinc while empty
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 1'b0, 2'd2, 2'd3, 1'b1}; // rinc while empty
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 2'd3, 1'b0}; // waddr=0 -> not empty
    tbl[7]  = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b1}; // wrap 2 -> 0
    tbl[8]  = '{1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0}; // waddr=2
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 2'd1, 1'b0}; // held rinc, read 1 of 3
    tbl[10] = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 2'd3, 1'b0}; // read 2, waddr moves to 0
    tbl[11] = '{1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b1}; // read 3 -> empty
    tbl[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1}; // held rinc, no read
    tbl[13] = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0}; // waddr=1
    tbl[14] = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 2'd0, 1'b1}; // reset overrides read
    tbl[15] = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0}; // first cycle out of reset
    tbl[16] = '{1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 2'd1, 1'b1}; // first read after reset

    // Bring the design out of its power-up state before any checks.
    rst = 1'b0; rinc = 1'b0; rq2_waddr = 2'd3;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].rinc, tbl[i].w, tbl[i].re, tbl[i].ra, tbl[i].rg,
           tbl[i].em, i);
    end

    // The model resumes from the state the table leaves behind.
    m_raddr = 1;
    m_empty = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic       r, ri, e_re;
      logic [1:0] w;
      int         nxt;
      r   = ($urandom_range(0, 19) != 0);
      ri  = 1'($urandom_range(0, 1));
      w   = 2'($urandom_range(0, 3));
      e_re = ri && !m_empty;
      if (!r) begin
        m_raddr = 0;
        m_empty = 1'b1;
      end else begin
        nxt     = e_re ? (m_raddr + 1) % DEPTH : m_raddr;
        m_raddr = nxt;
        m_empty = (nxt == model_g2b(int'(w)));
      end
      step(r, ri, w, e_re, 2'(m_raddr), 2'(m_raddr ^ (m_raddr >> 1)), m_empty,
           100 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got no finish expected finish");
    $fatal(1);
  end

endmodule
